gemm_operand_skewer: RTL and testbench
======================================

# gemm_operand_skewer

Upstream feeder for the GEMM systolic array of PE tiles. It accepts one A column vector and one B row vector per beat through a valid/ready handshake. Lane i of each operand is delayed by i cycles, and the skewed data drives the west (A) and north (B) edges of an N×N PE array. It also tracks the tile length, injects zeros for bubbles and flush, and signals completion once the last operand pair has been through PE(N-1,N-1).

## Interface
- DATA_WIDTH, 8: signed operand width, matching the PE operand width.
- N, 4: array dimension, which is also the lane count per operand; must be at least 2.
- K_MAX, 256: maximum tile depth in beats.
- clk  in  1  rising-edge clock.
- reset  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  tile start pulse; accepted only in IDLE.
- k_len  in  $clog2(K_MAX+1)  number of beats in the tile; sampled when start is accepted.
- a_vec  in  N*DATA_WIDTH  signed A elements; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH] and maps to array row i.
- b_vec  in  N*DATA_WIDTH  signed B elements; lane j maps to array column j.
- in_valid  in  1  a_vec/b_vec hold a valid beat.
- in_ready  out  1  block can take a beat. Combinational: high exactly when in STREAM.
- a_edge  out  N*DATA_WIDTH  skewed A lanes to the PE column-0 A_in ports.
- b_edge  out  N*DATA_WIDTH  skewed B lanes to the PE row-0 B_in ports.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the tile is complete.

## Operation
- States:
  - IDLE: on start, go to STREAM if k_len>0, otherwise go straight to DONE. Latch k_len and clear the beat counter.
  - STREAM: each cycle with in_valid&in_ready is an accept and increments the beat counter. On the accept that makes the count equal k_len, go to FLUSH.
  - FLUSH: runs exactly 2N-1 cycles, then goes to DONE.
  - DONE: one cycle with done=1, then returns to IDLE.
- Skew: lane i is a delay line of i+1 registers, so the output is always registered.
  - The value pushed into every lane each cycle is the input element on an accept, and 0 otherwise (bubbles in STREAM, and all of FLUSH, DONE and IDLE).
  - Zero injection keeps PE accumulation exact, because 0*x contributes nothing.
- Arithmetic: no arithmetic on the data. Signed values pass through bit-exact.
- start outside IDLE is ignored. in_valid outside STREAM is ignored and nothing is consumed.
- k_len values above K_MAX are clamped to K_MAX.
- Reset, including mid-tile: on the next edge,
  - all delay-line registers go to 0, so a_edge=b_edge=0;
  - state goes to IDLE, busy=0, done=0;
  - counters clear, and any partial tile is discarded.

## Timing
- Reset values: a_edge=0, b_edge=0, busy=0, done=0, in_ready=0.
- For a beat accepted in cycle T, lane i of a_edge/b_edge carries it during cycle T+1+i.
- The last beat, accepted in cycle T, reaches PE(i,j) A_in in cycle T+1+i+j. PE(N-1,N-1) C_out is valid in cycle T+2N.
- done is high in cycle T+2N.
- FLUSH spans cycles T+1 to T+2N-1.
- For k_len=0 with start in cycle S, done is high in cycle S+1.
- start can be accepted again in the cycle after done.

## Configuration
- GEMM_SKEW_BUBBLE_CNT_EN
  - Defined: adds output bubble_cnt (16 bits).
    - Counts STREAM cycles with in_valid=0 and saturates at 16'hFFFF.
    - Cleared to 0 by reset and by an accepted start.
    - Holds its value after done.
  - Undefined: the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- gemm_pkg holds:
  - the state enum (IDLE, STREAM, FLUSH, DONE);
  - the localparam function for the flush length (2N-1);
  - the k_len width helper.
- Sub-module skew_delay_line: a parameterized depth × width shift register with synchronous active-high reset. It is instantiated 2N times in a generate loop.

## Test plan
All scenarios use N=4, DATA_WIDTH=8.
- Reset held 3 cycles, then released → a_edge=b_edge=0, in_ready=0, busy=0, done=0.
- start with k_len=1, then accept a_vec lanes {1,2,3,4} in cycle T:
  - a_edge lane0=1 at T+1, lane1=2 at T+2, lane2=3 at T+3, lane3=4 at T+4;
  - all other lane-cycles are 0;
  - done at T+8.
- k_len=3 with in_valid low for one cycle between beats 1 and 2 → a zero column is inserted in every lane at the bubble slot; done 8 cycles after the third accept; bubble_cnt=1 with GEMM_SKEW_BUBBLE_CNT_EN defined.
- b_vec lanes {-128,127,-1,0} → b_edge lanes show -128, 127, -1, 0 bit-exact at their skewed cycles.
- start pulsed while busy → ignored, tile timing unchanged. k_len=0 → done in the cycle after start, in_ready never rises.
- reset asserted in the second STREAM cycle → next cycle all edges are 0 and busy=0. A subsequent start then runs a clean tile.

Source files
------------

// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared state encoding and sizing helpers for the GEMM operand skewer
package gemm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Cycles needed for the last beat to clear PE(N-1,N-1) after it is accepted.
    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int klen_width(input int k_max);
        return $clog2(k_max + 1);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH x WIDTH shift register with synchronous active-high reset
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/gemm_operand_skewer.sv
// rtl/gemm_operand_skewer.sv - skews A/B operand lanes into an NxN systolic array; GEMM_SKEW_BUBBLE_CNT_EN adds bubble_cnt
module gemm_operand_skewer
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int K_MAX      = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   k_len,
    input  logic [N*DATA_WIDTH-1:0]      a_vec,
    input  logic [N*DATA_WIDTH-1:0]      b_vec,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [N*DATA_WIDTH-1:0]      a_edge,
    output logic [N*DATA_WIDTH-1:0]      b_edge,
    output logic                         busy,
    output logic                         done
`ifdef GEMM_SKEW_BUBBLE_CNT_EN
    ,
    output logic [15:0]                  bubble_cnt
`endif
);

    localparam int KW        = klen_width(K_MAX);
    localparam int FLUSH_LEN = flush_len(N);
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    state_t         state_q, state_d;
    logic [KW-1:0]  k_len_q, k_len_d;
    logic [KW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
    logic [KW-1:0]  k_len_clamped;
    logic           accept;

    assign accept        = in_valid && (state_q == ST_STREAM);
    assign k_len_clamped = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_len_d    = k_len_clamped;
                    beat_cnt_d = '0;
                    state_d    = (k_len_clamped == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + KW'(1);
                    if ((beat_cnt_q + KW'(1)) == k_len_q) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = '0;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FW'(FLUSH_LEN - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready = (state_q == ST_STREAM);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

`ifdef GEMM_SKEW_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            bubble_cnt_d = '0;
        end else if ((state_q == ST_STREAM) && !in_valid && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

    // Anything other than an accepted beat enters the array as zero so PE sums stay exact.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_push, b_push;

        assign a_push = accept ? a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign b_push = accept ? b_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;

        skew_delay_line #(.DEPTH(i + 1), .WIDTH(DATA_WIDTH)) u_a_line (
            .clk   (clk),
            .reset (reset),
            .din   (a_push),
            .dout  (a_edge[i*DATA_WIDTH +: DATA_WIDTH])
        );

        skew_delay_line #(.DEPTH(i + 1), .WIDTH(DATA_WIDTH)) u_b_line (
            .clk   (clk),
            .reset (reset),
            .din   (b_push),
            .dout  (b_edge[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_gemm_operand_skewer.sv
// tb/tb_gemm_operand_skewer.sv - directed self-checking bench for gemm_operand_skewer (N=4, DATA_WIDTH=8)
module tb_gemm_operand_skewer;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int K_MAX = 256;
    localparam int KW    = 9;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [KW-1:0]   k_len;
    logic [N*DW-1:0] a_vec, b_vec;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] a_edge, b_edge;
    logic            busy;
    logic            done;
`ifdef GEMM_SKEW_BUBBLE_CNT_EN
    logic [15:0]     bubble_cnt;
`endif

    gemm_operand_skewer #(.DATA_WIDTH(DW), .N(N), .K_MAX(K_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .k_len      (k_len),
        .a_vec      (a_vec),
        .b_vec      (b_vec),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_edge     (a_edge),
        .b_edge     (b_edge),
        .busy       (busy),
        .done       (done)
`ifdef GEMM_SKEW_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         a_in  [4];
        int         b_in  [4];
        logic [7:0] a_exp [4];
        logic [7:0] b_exp [4];
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pack(input int v [4]);
        logic [31:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i*8 +: 8] = v[i][7:0];
        end
        return p;
    endfunction

    // Lane i carries its element only in relative cycle 1+i after the accept.
    function automatic logic [31:0] lane_at(input logic [7:0] e [4], input int c);
        logic [31:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i*8 +: 8] = (c == 1 + i) ? e[i] : 8'h00;
        end
        return p;
    endfunction

    // Single-beat tile; optionally pulses start while busy, which must be ignored.
    task automatic run_single(input int idx, input string tag, input bit poke_start);
        start = 1'b1;
        k_len = 9'd1;
        step();
        start = 1'b0;
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        a_vec    = pack(vecs[idx].a_in);
        b_vec    = pack(vecs[idx].b_in);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a_vec    = 32'hA5A5_A5A5;
        b_vec    = 32'h5A5A_5A5A;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("%s_a_c%0d", tag, c), a_edge, lane_at(vecs[idx].a_exp, c));
            chk($sformatf("%s_b_c%0d", tag, c), b_edge, lane_at(vecs[idx].b_exp, c));
            chk($sformatf("%s_done_c%0d", tag, c), {31'd0, done}, (c == 8) ? 32'd1 : 32'd0);
            chk($sformatf("%s_busy_c%0d", tag, c), {31'd0, busy}, 32'd1);
            if (poke_start && (c == 2 || c == 5 || c == 8)) begin
                start = 1'b1;
                k_len = 9'd5;
                in_valid = 1'b1;
            end else begin
                start = 1'b0;
                in_valid = 1'b0;
            end
            step();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    logic [31:0] da [4];
    logic [31:0] db [4];
    bit          vld [4];

    function automatic logic [31:0] model_edge(input logic [31:0] d [4], input bit v [4], input int t);
        logic [31:0] p;
        int idx;
        for (int i = 0; i < 4; i++) begin
            idx = t - 1 - i;
            p[i*8 +: 8] = (idx >= 0 && idx <= 3 && v[idx]) ? d[idx][i*8 +: 8] : 8'h00;
        end
        return p;
    endfunction

    initial begin
        vecs[0] = '{'{1, 2, 3, 4},       '{-128, 127, -1, 0},
                    '{8'h01, 8'h02, 8'h03, 8'h04}, '{8'h80, 8'h7F, 8'hFF, 8'h00}};
        vecs[1] = '{'{-1, -2, 127, -128}, '{5, 6, 7, 8},
                    '{8'hFF, 8'hFE, 8'h7F, 8'h80}, '{8'h05, 8'h06, 8'h07, 8'h08}};
        vecs[2] = '{'{100, -100, 64, -64}, '{-3, 33, -77, 90},
                    '{8'h64, 8'h9C, 8'h40, 8'hC0}, '{8'hFD, 8'h21, 8'hB3, 8'h5A}};

        reset    = 1'b1;
        start    = 1'b0;
        k_len    = '0;
        a_vec    = 32'hDEAD_BEEF;
        b_vec    = 32'hCAFE_F00D;
        in_valid = 1'b0;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        chk("rst_a_edge", a_edge, 32'd0);
        chk("rst_b_edge", b_edge, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        for (int v = 0; v < 3; v++) begin
            run_single(v, $sformatf("vec%0d", v), 1'b0);
        end

        // k_len=3 with a bubble between beats 1 and 2.
        da[0] = 32'h14131211; vld[0] = 1'b1; db[0] = 32'h84838281;
        da[1] = 32'hEEEEEEEE; vld[1] = 1'b0; db[1] = 32'hEEEEEEEE;
        da[2] = 32'h24232221; vld[2] = 1'b1; db[2] = 32'h94939291;
        da[3] = 32'h34333231; vld[3] = 1'b1; db[3] = 32'hA4A3A2A1;
        start = 1'b1;
        k_len = 9'd3;
        step();
        start = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            if (r <= 3) begin
                in_valid = vld[r];
                a_vec    = da[r];
                b_vec    = db[r];
            end else begin
                in_valid = 1'b0;
                a_vec    = 32'h77777777;
                b_vec    = 32'h77777777;
            end
            if (r == 1) chk("bub_ready_in_gap", {31'd0, in_ready}, 32'd1);
            step();
            chk($sformatf("bub_a_t%0d", r + 1), a_edge, model_edge(da, vld, r + 1));
            chk($sformatf("bub_b_t%0d", r + 1), b_edge, model_edge(db, vld, r + 1));
            chk($sformatf("bub_done_t%0d", r + 1), {31'd0, done}, (r + 1 == 11) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        step();
        chk("bub_idle_busy", {31'd0, busy}, 32'd0);
`ifdef GEMM_SKEW_BUBBLE_CNT_EN
        chk("bub_cnt", {16'd0, bubble_cnt}, 32'd1);
`endif

        run_single(2, "busy_start", 1'b1);

        start = 1'b1;
        k_len = 9'd0;
        step();
        start = 1'b0;
        chk("k0_done", {31'd0, done}, 32'd1);
        chk("k0_ready", {31'd0, in_ready}, 32'd0);
        chk("k0_busy", {31'd0, busy}, 32'd1);
        step();
        chk("k0_done_after", {31'd0, done}, 32'd0);
        chk("k0_busy_after", {31'd0, busy}, 32'd0);
        chk("k0_ready_after", {31'd0, in_ready}, 32'd0);

        // Reset in the second STREAM cycle discards the partial tile.
        start = 1'b1;
        k_len = 9'd4;
        step();
        start    = 1'b0;
        a_vec    = pack(vecs[0].a_in);
        b_vec    = pack(vecs[0].b_in);
        in_valid = 1'b1;
        step();
        chk("mid_ready_pre", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mid_a_edge", a_edge, 32'd0);
        chk("mid_b_edge", b_edge, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        run_single(1, "post_rst", 1'b0);

        // k_len above K_MAX clamps to 256 beats.
        begin
            int accepts;
            accepts = 0;
            start = 1'b1;
            k_len = 9'd300;
            step();
            start = 1'b0;
            for (int c = 0; c < 300 && in_ready; c++) begin
                in_valid = 1'b1;
                a_vec    = c;
                b_vec    = ~c;
                step();
                accepts++;
            end
            in_valid = 1'b0;
            chk("clamp_accepts", accepts, 32'd256);
            for (int c = 1; c <= 8; c++) begin
                chk($sformatf("clamp_done_c%0d", c), {31'd0, done}, (c == 8) ? 32'd1 : 32'd0);
                step();
            end
            chk("clamp_idle", {31'd0, busy}, 32'd0);
`ifdef GEMM_SKEW_BUBBLE_CNT_EN
            chk("clamp_bub_cnt", {16'd0, bubble_cnt}, 32'd0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
